// File: rtl/round_sgf_apply.sv
// round_sgf_apply: applies the round-up decision to a normalized significand.
// Two-stage valid/ready pipeline: S1 forms the incremented significand,
// S2 renormalizes on carry-out and saturates to infinity on exponent overflow.
module round_sgf_apply #(
  parameter int SW = 24,
  parameter int EW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic [SW-1:0] Sgf_i,
  input  logic [EW-1:0] Exp_i,
  input  logic          Sign_Result_i,
  input  logic          Round_Flag_i,
  input  logic [1:0]    Data_i,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [SW-1:0] Sgf_o,
  output logic [EW-1:0] Exp_o,
  output logic          Sign_o,
  output logic          Overflow_o,
  output logic          Inexact_o
);

  localparam logic [EW-1:0] EXP_MAX = {EW{1'b1}};

  // Renormalize after the increment and saturate to infinity.
  // Result packing: {overflow, exponent, significand}.
  function automatic logic [SW+EW:0] apply_round(input logic [SW:0] sum,
                                                 input logic [EW-1:0] exp_in);
    logic [SW-1:0] sgf_r;
    logic [EW-1:0] exp_r;
    logic          ovf_r;
    if (sum[SW]) begin
      // All-ones significand rolled over: 1.000... with exponent bumped.
      sgf_r = {1'b1, {(SW-1){1'b0}}};
      exp_r = exp_in + {{(EW-1){1'b0}}, 1'b1};
    end else begin
      sgf_r = sum[SW-1:0];
      exp_r = exp_in;
    end
    ovf_r = (exp_r == EXP_MAX);
    if (ovf_r) begin
      sgf_r = '0;
      exp_r = EXP_MAX;
    end
    return {ovf_r, exp_r, sgf_r};
  endfunction

  // Pipeline state
  logic          v1_q, v1_d, v2_q, v2_d;
  logic [SW:0]   sum1_q, sum1_d;
  logic [EW-1:0] exp1_q, exp1_d;
  logic          sign1_q, sign1_d, inex1_q, inex1_d;
  logic [SW-1:0] sgf2_q, sgf2_d;
  logic [EW-1:0] exp2_q, exp2_d;
  logic          sign2_q, sign2_d, ovf2_q, ovf2_d, inex2_q, inex2_d;

  logic          load2, load1, accept, move;
  logic [SW+EW:0] rnd;

  // Handshake: S2 frees when empty or draining; S1 frees when empty or moving on.
  always_comb begin
    load2   = ~v2_q | ready_i;
    load1   = ~v1_q | load2;
    ready_o = ~v1_q | ~v2_q | ready_i;
    accept  = valid_i & ready_o;
    move    = v1_q & load2;
  end

  // Next-state for valid bits and both stage data registers.
  always_comb begin
    v1_d    = load1 ? valid_i : v1_q;
    v2_d    = load2 ? v1_q : v2_q;

    sum1_d  = sum1_q;
    exp1_d  = exp1_q;
    sign1_d = sign1_q;
    inex1_d = inex1_q;
    if (accept) begin
      sum1_d  = {1'b0, Sgf_i} + {{SW{1'b0}}, Round_Flag_i};
      exp1_d  = Exp_i;
      sign1_d = Sign_Result_i;
      inex1_d = |Data_i;
    end

    rnd     = apply_round(sum1_q, exp1_q);
    sgf2_d  = sgf2_q;
    exp2_d  = exp2_q;
    sign2_d = sign2_q;
    ovf2_d  = ovf2_q;
    inex2_d = inex2_q;
    if (move) begin
      sgf2_d  = rnd[SW-1:0];
      exp2_d  = rnd[SW+EW-1:SW];
      ovf2_d  = rnd[SW+EW];
      sign2_d = sign1_q;
      inex2_d = inex1_q | rnd[SW+EW];
    end
  end

  // Stage registers; reset discards in-flight beats and clears data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      sum1_q  <= '0;
      exp1_q  <= '0;
      sign1_q <= 1'b0;
      inex1_q <= 1'b0;
      sgf2_q  <= '0;
      exp2_q  <= '0;
      sign2_q <= 1'b0;
      ovf2_q  <= 1'b0;
      inex2_q <= 1'b0;
    end else begin
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      sum1_q  <= sum1_d;
      exp1_q  <= exp1_d;
      sign1_q <= sign1_d;
      inex1_q <= inex1_d;
      sgf2_q  <= sgf2_d;
      exp2_q  <= exp2_d;
      sign2_q <= sign2_d;
      ovf2_q  <= ovf2_d;
      inex2_q <= inex2_d;
    end
  end

  // Outputs come straight from S2 registers.
  always_comb begin
    valid_o    = v2_q;
    Sgf_o      = sgf2_q;
    Exp_o      = exp2_q;
    Sign_o     = sign2_q;
    Overflow_o = ovf2_q;
    Inexact_o  = inex2_q;
  end

endmodule

// File: tb/tb_round_sgf_apply.sv
// Directed bench for round_sgf_apply.
module tb_round_sgf_apply;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, ready_o, valid_o, ready_i;
  logic [23:0] Sgf_i, Sgf_o;
  logic [7:0]  Exp_i, Exp_o;
  logic        Sign_Result_i, Round_Flag_i, Sign_o, Overflow_o, Inexact_o;
  logic [1:0]  Data_i;

  int ntests = 0;
  int nfail  = 0;

  round_sgf_apply #(.SW(24), .EW(8)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .Sgf_i(Sgf_i), .Exp_i(Exp_i), .Sign_Result_i(Sign_Result_i),
    .Round_Flag_i(Round_Flag_i), .Data_i(Data_i), .valid_o(valid_o),
    .ready_i(ready_i), .Sgf_o(Sgf_o), .Exp_o(Exp_o), .Sign_o(Sign_o),
    .Overflow_o(Overflow_o), .Inexact_o(Inexact_o)
  );

  always #5 clk = ~clk;

  // {Sgf, Exp, Sign, Overflow, Inexact}
  function automatic logic [34:0] outv();
    return {Sgf_o, Exp_o, Sign_o, Overflow_o, Inexact_o};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    ntests++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic v, input logic [23:0] s, input logic [7:0] e,
                       input logic sg, input logic rf, input logic [1:0] d);
    valid_i = v; Sgf_i = s; Exp_i = e; Sign_Result_i = sg; Round_Flag_i = rf; Data_i = d;
  endtask

  // One beat with ready_i high: checks acceptance, 2-cycle latency and result.
  task automatic run_one(input string tag, input logic [23:0] s, input logic [7:0] e,
                         input logic sg, input logic rf, input logic [1:0] d,
                         input logic [34:0] expv);
    @(negedge clk);
    ready_i = 1'b1;
    drive(1'b1, s, e, sg, rf, d);
    #1 chk({tag, "_rdy"}, 64'(ready_o), 64'd1);
    @(negedge clk);
    drive(1'b0, 24'h0, 8'h0, 1'b0, 1'b0, 2'b00);
    chk({tag, "_lat1"}, 64'(valid_o), 64'd0);
    @(negedge clk);
    chk({tag, "_vld"}, 64'(valid_o), 64'd1);
    chk({tag, "_out"}, 64'(outv()), 64'(expv));
  endtask

  logic [23:0] bp_s [5];
  logic [7:0]  bp_e [5];
  logic        bp_sg[5];
  logic        bp_rf[5];
  logic [1:0]  bp_d [5];
  logic [34:0] bp_x [5];

  initial begin
    int in_idx, out_idx, acc_at_stall, first_stall;
    logic [34:0] snap;
    logic had_valid;

    rst = 1'b1; ready_i = 1'b1;
    drive(1'b0, 24'h0, 8'h0, 1'b0, 1'b0, 2'b00);
    #3;
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_out",   64'(outv()), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_one("pass",  24'hC00000, 8'h80, 1'b0, 1'b0, 2'b00, {24'hC00000, 8'h80, 1'b0, 1'b0, 1'b0});
    run_one("inc",   24'h800001, 8'h7F, 1'b0, 1'b1, 2'b10, {24'h800002, 8'h7F, 1'b0, 1'b0, 1'b1});
    run_one("carry", 24'hFFFFFF, 8'h7F, 1'b0, 1'b1, 2'b11, {24'h800000, 8'h80, 1'b0, 1'b0, 1'b1});
    run_one("ovf",   24'hFFFFFF, 8'hFE, 1'b1, 1'b1, 2'b00, {24'h000000, 8'hFF, 1'b1, 1'b1, 1'b1});

    // Backpressure stream: five beats, ready_i low for the first four cycles.
    bp_s[0] = 24'h800010; bp_e[0] = 8'h10; bp_sg[0] = 1'b0; bp_rf[0] = 1'b0; bp_d[0] = 2'b00;
    bp_x[0] = {24'h800010, 8'h10, 1'b0, 1'b0, 1'b0};
    bp_s[1] = 24'h800020; bp_e[1] = 8'h11; bp_sg[1] = 1'b1; bp_rf[1] = 1'b1; bp_d[1] = 2'b01;
    bp_x[1] = {24'h800021, 8'h11, 1'b1, 1'b0, 1'b1};
    bp_s[2] = 24'hFFFFFF; bp_e[2] = 8'h12; bp_sg[2] = 1'b0; bp_rf[2] = 1'b1; bp_d[2] = 2'b00;
    bp_x[2] = {24'h800000, 8'h13, 1'b0, 1'b0, 1'b0};
    bp_s[3] = 24'hA00000; bp_e[3] = 8'h13; bp_sg[3] = 1'b1; bp_rf[3] = 1'b0; bp_d[3] = 2'b10;
    bp_x[3] = {24'hA00000, 8'h13, 1'b1, 1'b0, 1'b1};
    bp_s[4] = 24'hFFFFFF; bp_e[4] = 8'hFE; bp_sg[4] = 1'b0; bp_rf[4] = 1'b1; bp_d[4] = 2'b00;
    bp_x[4] = {24'h000000, 8'hFF, 1'b0, 1'b1, 1'b1};

    in_idx = 0; out_idx = 0; first_stall = -1; acc_at_stall = -1;
    had_valid = 1'b0; snap = '0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      ready_i = (cyc >= 4);
      if (in_idx < 5)
        drive(1'b1, bp_s[in_idx], bp_e[in_idx], bp_sg[in_idx], bp_rf[in_idx], bp_d[in_idx]);
      else
        drive(1'b0, 24'h0, 8'h0, 1'b0, 1'b0, 2'b00);
      #1;
      if (valid_o) begin
        if (had_valid && cyc <= 4)
          chk("bp_stable", 64'(outv()), 64'(snap));
        if (ready_i) begin
          if (out_idx < 5) chk($sformatf("bp_beat%0d", out_idx), 64'(outv()), 64'(bp_x[out_idx]));
          out_idx++;
        end
        snap = outv();
        had_valid = 1'b1;
      end
      if (!ready_o && first_stall < 0) begin
        first_stall = cyc;
        acc_at_stall = in_idx;
      end
      if (valid_i && ready_o) in_idx++;
    end
    chk("bp_stall_cyc",  64'(first_stall), 64'd2);
    chk("bp_stall_accd", 64'(acc_at_stall), 64'd2);
    chk("bp_all_out",    64'(out_idx), 64'd5);
    chk("bp_drained",    64'(valid_o), 64'd0);

    // Reset mid-flight: two beats in the pipe, reset pulsed between edges.
    @(negedge clk);
    ready_i = 1'b0;
    drive(1'b1, 24'h900000, 8'h40, 1'b1, 1'b1, 2'b01);
    @(negedge clk);
    drive(1'b1, 24'hA00000, 8'h41, 1'b1, 1'b0, 2'b11);
    @(posedge clk);
    #2;
    drive(1'b0, 24'h0, 8'h0, 1'b0, 1'b0, 2'b00);
    chk("mid_full", 64'({valid_o, ready_o}), 64'b10);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(valid_o), 64'd0);
    chk("mid_rst_ready", 64'(ready_o), 64'd1);
    chk("mid_rst_out",   64'(outv()), 64'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    ready_i = 1'b1;
    chk("mid_empty", 64'(valid_o), 64'd0);
    run_one("post", 24'h800003, 8'h22, 1'b0, 1'b1, 2'b00, {24'h800004, 8'h22, 1'b0, 1'b0, 1'b0});

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
